// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared encodings and helpers for the data-memory controller
package dmem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) | ((size == SIZE_H) & lo[0]) | ((size == SIZE_W) & (lo != 2'b00));
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: store lane alignment/mask, load extraction/extension, misalignment flag
module dmem_lane_fmt
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_al,
  output logic [3:0]  mask,
  output logic [31:0] rdata_ext,
  output logic        err
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    err = misaligned(size, lo);
    b = 8'(rdata >> {lo, 3'b000});
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    wdata_al = (size == SIZE_B) ? {4{wdata[7:0]}} : (size == SIZE_H) ? {2{wdata[15:0]}} : wdata;
    mask = (size == SIZE_B) ? (4'b0001 << lo) : (size == SIZE_H) ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rdata_ext = (size == SIZE_B) ? {{24{~uns & b[7]}}, b} :
                (size == SIZE_H) ? {{16{~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: arbitrates CPU and loader onto the single-port data RAM, one access per two cycles
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [1:0]        c_size,
  input  logic              c_unsigned,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              ram_read_op,
  output logic              ram_write_op,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_mask,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_e state_q, state_d;
  logic pref_l_q, pref_l_d, sel_l_q, sel_l_d, we_q, we_d, uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic c_rvalid_q, c_rvalid_d, c_err_q, c_err_d, l_rvalid_q, l_rvalid_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d, l_rdata_q, l_rdata_d;
  logic accept, c_win, access, err;
  logic [DATA_W-1:0] wdata_al, rdata_ext;
  logic [3:0] mask;

  dmem_lane_fmt u_fmt (
    .size(size_q), .lo(addr_q[1:0]), .uns(uns_q), .wdata(wdata_q), .rdata(ram_rdata),
    .wdata_al(wdata_al), .mask(mask), .rdata_ext(rdata_ext), .err(err)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      pref_l_q   <= 1'b0;
      sel_l_q    <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      l_rvalid_q <= 1'b0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      pref_l_q   <= pref_l_d;
      sel_l_q    <= sel_l_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      c_rvalid_q <= c_rvalid_d;
      c_err_q    <= c_err_d;
      c_rdata_q  <= c_rdata_d;
      l_rvalid_q <= l_rvalid_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  always_comb begin
    state_d = rst ? IDLE : (state_q == ACCESS) ? RESP : accept ? ACCESS : IDLE;
  end

  // Loader requests are normalised to aligned word accesses when latched
  always_comb begin
    access = state_q == ACCESS;
    accept = !rst & (state_q != ACCESS) & (c_req | l_req);
    c_win = c_req & (!l_req | !RR_EN | !pref_l_q);
    pref_l_d = accept ? c_win : pref_l_q;
    sel_l_d = accept ? !c_win : sel_l_q;
    we_d = accept ? (c_win ? c_we : l_we) : we_q;
    uns_d = accept ? (c_win & c_unsigned) : uns_q;
    addr_d = accept ? (c_win ? c_addr : {l_addr[ADDR_W-1:2], 2'b00}) : addr_q;
    size_d = accept ? (c_win ? c_size : SIZE_W) : size_q;
    wdata_d = accept ? (c_win ? c_wdata : l_wdata) : wdata_q;
    c_rvalid_d = access & !sel_l_q;
    l_rvalid_d = access & sel_l_q;
    c_rdata_d = c_rvalid_d ? ((err | we_q) ? ZERO_WORD : rdata_ext) : c_rdata_q;
    c_err_d = c_rvalid_d ? err : c_err_q;
    l_rdata_d = l_rvalid_d ? (we_q ? ZERO_WORD : ram_rdata) : l_rdata_q;
  end

  always_comb begin
    c_gnt = accept & c_win;
    l_gnt = accept & !c_win;
    c_rvalid = c_rvalid_q;
    c_rdata = c_rdata_q;
    c_err = c_err_q;
    l_rvalid = l_rvalid_q;
    l_rdata = l_rdata_q;
    ram_read_op = access & !we_q & !err;
    ram_write_op = access & we_q & !err & !rst;
    ram_addr = access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    ram_mask = (access & !err) ? mask : 4'b0000;
    ram_wdata = access ? wdata_al : '0;
  end
endmodule
